// File: rtl/rv_decode_stage_if.sv
// Fetch -> decode -> execute bundle for the uRV decode stage.
// Latency: none (wires only).
// Backpressure: d_stall_i from execute holds decode; f_stall_o back-pressures fetch.
//
// Port summary:
//   fetch side   : f_ir_i, f_pc_i, f_valid_i (in), f_stall_o (out)
//   execute side : d_stall_i, d_kill_i (in), x_* decoded fields (out)
//   regfile side : d_rf_rs1_o, d_rf_rs2_o (out, combinational read addresses)
// The slave modport is the decode stage; master is its surroundings.
interface rv_decode_stage_if;
  logic [31:0] f_ir_i;
  logic [31:0] f_pc_i;
  logic        f_valid_i;
  logic        d_stall_i;
  logic        d_kill_i;
  logic        f_stall_o;
  logic [4:0]  d_rf_rs1_o;
  logic [4:0]  d_rf_rs2_o;
  logic        x_valid_o;
  logic [31:0] x_pc_o;
  logic [31:0] x_ir_o;
  logic [4:0]  x_opcode_o;
  logic [2:0]  x_fun3_o;
  logic [6:0]  x_fun7_o;
  logic [4:0]  x_rs1_o;
  logic [4:0]  x_rs2_o;
  logic [4:0]  x_rd_o;
  logic [31:0] x_imm_o;
  logic        x_is_load_o;
  logic        x_is_store_o;
  logic        x_is_branch_o;
  logic        x_is_jump_o;
  logic        x_illegal_o;

  modport slave (
    input  f_ir_i, f_pc_i, f_valid_i, d_stall_i, d_kill_i,
    output f_stall_o, d_rf_rs1_o, d_rf_rs2_o,
    output x_valid_o, x_pc_o, x_ir_o, x_opcode_o, x_fun3_o, x_fun7_o,
    output x_rs1_o, x_rs2_o, x_rd_o, x_imm_o,
    output x_is_load_o, x_is_store_o, x_is_branch_o, x_is_jump_o, x_illegal_o
  );

  modport master (
    output f_ir_i, f_pc_i, f_valid_i, d_stall_i, d_kill_i,
    input  f_stall_o, d_rf_rs1_o, d_rf_rs2_o,
    input  x_valid_o, x_pc_o, x_ir_o, x_opcode_o, x_fun3_o, x_fun7_o,
    input  x_rs1_o, x_rs2_o, x_rd_o, x_imm_o,
    input  x_is_load_o, x_is_store_o, x_is_branch_o, x_is_jump_o, x_illegal_o
  );
endinterface

// File: rtl/rv_decode_stage.sv
// uRV decode stage: registers fetch word/PC, splits fields, builds immediate, flags classes.
// Latency: one cycle from fetch word to x_* outputs.
// Backpressure: d_stall_i freezes all x_* state; f_stall_o = d_stall_i | load-use hazard.
//
// Port summary:
//   clk_i, rst_n_i : core clock, asynchronous active-low reset
//   bus (slave)    : fetch inputs, execute stall/kill, decoded x_* outputs,
//                    f_stall_o to fetch, d_rf_rs1_o/d_rf_rs2_o to the register file
module rv_decode_stage #(
  parameter bit g_with_hazard_unit = 1'b1,
  parameter bit g_check_illegal    = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  rv_decode_stage_if.slave  bus
);

  // Major opcodes, ir[6:2]
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // ------------------------------------------------------------------
  // Combinational decode of the incoming fetch word
  // ------------------------------------------------------------------
  logic [31:0] ir;
  logic [4:0]  dec_opcode;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [31:0] dec_imm;
  logic        dec_is_load;
  logic        dec_is_store;
  logic        dec_is_branch;
  logic        dec_is_jump;
  logic        dec_reads_rs1;
  logic        dec_reads_rs2;
  logic        dec_known_opc;
  logic        dec_illegal;

  assign ir         = bus.f_ir_i;
  assign dec_opcode = ir[6:2];
  assign dec_rs1    = ir[19:15];
  assign dec_rs2    = ir[24:20];

  always_comb begin
    dec_imm       = 32'h0;
    dec_is_load   = 1'b0;
    dec_is_store  = 1'b0;
    dec_is_branch = 1'b0;
    dec_is_jump   = 1'b0;
    dec_reads_rs1 = 1'b0;
    dec_reads_rs2 = 1'b0;
    dec_known_opc = 1'b1;
    case (dec_opcode)
      OPC_LOAD: begin
        dec_imm       = {{20{ir[31]}}, ir[31:20]};
        dec_is_load   = 1'b1;
        dec_reads_rs1 = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_imm       = {{20{ir[31]}}, ir[31:20]};
        dec_reads_rs1 = 1'b1;
      end
      OPC_JALR: begin
        dec_imm       = {{20{ir[31]}}, ir[31:20]};
        dec_is_jump   = 1'b1;
        dec_reads_rs1 = 1'b1;
      end
      OPC_SYSTEM: begin
        dec_imm = {{20{ir[31]}}, ir[31:20]};
      end
      OPC_STORE: begin
        dec_imm       = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        dec_is_store  = 1'b1;
        dec_reads_rs1 = 1'b1;
        dec_reads_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm       = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        dec_is_branch = 1'b1;
        dec_reads_rs1 = 1'b1;
        dec_reads_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_imm = {ir[31:12], 12'h000};
      end
      OPC_JAL: begin
        dec_imm     = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        dec_is_jump = 1'b1;
      end
      OPC_OP: begin
        dec_reads_rs1 = 1'b1;
        dec_reads_rs2 = 1'b1;
      end
      OPC_MISC_MEM: begin
        dec_imm = 32'h0;
      end
      default: begin
        dec_known_opc = 1'b0;
      end
    endcase
  end

  // Branches and stores have no destination; zeroing rd here keeps the
  // hazard check and any downstream writeback logic from seeing a phantom rd.
  assign dec_rd = (dec_is_branch || dec_is_store) ? 5'd0 : ir[11:7];

  generate
    if (g_check_illegal) begin : g_illegal_on
      assign dec_illegal = (ir[1:0] != 2'b11) || !dec_known_opc;
    end else begin : g_illegal_off
      assign dec_illegal = 1'b0;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Pipeline registers
  // ------------------------------------------------------------------
  logic        x_valid_q;
  logic [31:0] x_pc_q;
  logic [31:0] x_ir_q;
  logic [4:0]  x_rd_q;
  logic [31:0] x_imm_q;
  logic        x_is_load_q;
  logic        x_is_store_q;
  logic        x_is_branch_q;
  logic        x_is_jump_q;
  logic        x_illegal_q;

  // ------------------------------------------------------------------
  // Load-use hazard: the load in execute has not produced its data yet,
  // so a dependent instruction must wait one cycle. A kill squashes the
  // decoding instruction anyway, so no stall is needed then.
  // ------------------------------------------------------------------
  logic hazard;

  generate
    if (g_with_hazard_unit) begin : g_hazard_on
      logic rs1_dep;
      logic rs2_dep;
      assign rs1_dep = dec_reads_rs1 && (dec_rs1 == x_rd_q);
      assign rs2_dep = dec_reads_rs2 && (dec_rs2 == x_rd_q);
      assign hazard  = !bus.d_kill_i && bus.f_valid_i && x_valid_q &&
                       x_is_load_q && (x_rd_q != 5'd0) && (rs1_dep || rs2_dep);
    end else begin : g_hazard_off
      assign hazard = 1'b0;
    end
  endgenerate

  // Fields always follow the fetch word when not stalled; only the valid
  // bit distinguishes a real issue from a kill or a bubble. During a bubble
  // fetch is held, so the same word is decoded again next cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      x_valid_q     <= 1'b0;
      x_pc_q        <= 32'h0;
      x_ir_q        <= 32'h0;
      x_rd_q        <= 5'd0;
      x_imm_q       <= 32'h0;
      x_is_load_q   <= 1'b0;
      x_is_store_q  <= 1'b0;
      x_is_branch_q <= 1'b0;
      x_is_jump_q   <= 1'b0;
      x_illegal_q   <= 1'b0;
    end else if (!bus.d_stall_i) begin
      x_valid_q     <= bus.f_valid_i && !bus.d_kill_i && !hazard;
      x_pc_q        <= bus.f_pc_i;
      x_ir_q        <= ir;
      x_rd_q        <= dec_rd;
      x_imm_q       <= dec_imm;
      x_is_load_q   <= dec_is_load;
      x_is_store_q  <= dec_is_store;
      x_is_branch_q <= dec_is_branch;
      x_is_jump_q   <= dec_is_jump;
      x_illegal_q   <= dec_illegal;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.f_stall_o     = bus.d_stall_i || hazard;

  assign bus.x_valid_o     = x_valid_q;
  assign bus.x_pc_o        = x_pc_q;
  assign bus.x_ir_o        = x_ir_q;
  // Plain field slices come straight from the registered word.
  assign bus.x_opcode_o    = x_ir_q[6:2];
  assign bus.x_fun3_o      = x_ir_q[14:12];
  assign bus.x_fun7_o      = x_ir_q[31:25];
  assign bus.x_rs1_o       = x_ir_q[19:15];
  assign bus.x_rs2_o       = x_ir_q[24:20];
  assign bus.x_rd_o        = x_rd_q;
  assign bus.x_imm_o       = x_imm_q;
  assign bus.x_is_load_o   = x_is_load_q;
  assign bus.x_is_store_o  = x_is_store_q;
  assign bus.x_is_branch_o = x_is_branch_q;
  assign bus.x_is_jump_o   = x_is_jump_q;
  assign bus.x_illegal_o   = x_illegal_q;

  // A synchronous register file reads on the same edge that loads x_*;
  // while stalled, re-read the held operands so the read data stays
  // paired with the held instruction.
  assign bus.d_rf_rs1_o = bus.d_stall_i ? x_ir_q[19:15] : dec_rs1;
  assign bus.d_rf_rs2_o = bus.d_stall_i ? x_ir_q[24:20] : dec_rs2;

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Second pipeline stage of the uRV core. Sits directly downstream of the fetch stage and upstream of execute.
- Registers the fetched instruction word and PC, splits out register and function fields, and builds the sign-extended immediate for the instruction format.
- Flags loads, stores, branches, jumps and illegal encodings.
- Detects load-use hazards and inserts exactly one bubble, stalling fetch for that cycle.

Parameters:
- g_with_hazard_unit, 1, 1 enables load-use bubble insertion; 0 disables it, so the hazard signal is constant 0.
- g_check_illegal, 1, 1 enables illegal-opcode detection; 0 forces x_illegal_o to 0.

Ports:
- clk_i  in  1  core clock.
- rst_n_i  in  1  asynchronous active-low reset.
- f_ir_i  in  32  instruction word from fetch.
- f_pc_i  in  32  PC of f_ir_i.
- f_valid_i  in  1  f_ir_i/f_pc_i valid.
- d_stall_i  in  1  execute cannot accept; hold all outputs.
- d_kill_i  in  1  taken branch/jump in execute; squash the instruction currently in decode.
- f_stall_o  out  1  stall request to fetch: d_stall_i OR hazard.
- d_rf_rs1_o  out  5  register-file read address 1 (combinational).
- d_rf_rs2_o  out  5  register-file read address 2 (combinational).
- x_valid_o  out  1  decoded instruction valid for execute.
- x_pc_o  out  32  registered PC.
- x_ir_o  out  32  registered instruction word.
- x_opcode_o  out  5  ir[6:2].
- x_fun3_o  out  3  ir[14:12].
- x_fun7_o  out  7  ir[31:25].
- x_rs1_o  out  5  ir[19:15].
- x_rs2_o  out  5  ir[24:20].
- x_rd_o  out  5  ir[11:7]; forced to 0 for branch and store.
- x_imm_o  out  32  sign-extended immediate.
- x_is_load_o, x_is_store_o, x_is_branch_o, x_is_jump_o  out  1 each  class flags; x_is_jump_o covers JAL and JALR.
- x_illegal_o  out  1  unsupported or malformed encoding.

Behaviour:
- Reset (async, rst_n_i=0): every x_* output is 0, including x_valid_o. f_stall_o is driven only by d_stall_i during reset. Reset can assert mid-stall; release is clean on the next edge with x_valid_o=0.
- Latency: one cycle. A fetch word accepted on edge N appears on x_* after edge N.
- Hazard (combinational) is 1 when all of the following hold:
  - g_with_hazard_unit=1;
  - f_valid_i=1, x_valid_o=1, x_is_load_o=1 and x_rd_o!=0;
  - the decoding instruction reads rs1 and rs1==x_rd_o, or reads rs2 and rs2==x_rd_o.
- Register reads:
  - rs1 is read by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 is read by BRANCH, STORE and OP.
  - LUI, AUIPC and JAL read no registers.
- d_kill_i=1 overrides hazard. Hazard is forced to 0 during a kill.
- Update rule per clock edge:
  - d_stall_i=1: all x_* registers hold; kill is ignored. Execute must hold its kill until unstalled.
  - Else if d_kill_i=1: x_valid_o<=0; other fields may update.
  - Else if hazard=1: x_valid_o<=0 (bubble); the load's fields are not retained. Fetch is stalled through f_stall_o, so f_ir_i is unchanged and re-decodes next cycle with the hazard cleared. Exactly one bubble per load-use pair.
  - Else: all fields <= decode(f_ir_i); x_pc_o<=f_pc_i; x_valid_o<=f_valid_i.
- d_rf_rs1_o/d_rf_rs2_o: equal to x_rs1_o/x_rs2_o when d_stall_i=1, otherwise f_ir_i[19:15]/f_ir_i[24:20]. This keeps a synchronous register file aligned with x_*.
- Immediate by opcode:
  - I-type (LOAD, OP-IMM, JALR, SYSTEM): sext(ir[31:20]).
  - S-type: sext({ir[31:25],ir[11:7]}).
  - B-type: sext({ir[31],ir[7],ir[30:25],ir[11:8],0}).
  - U-type (LUI, AUIPC): {ir[31:12],12'b0}.
  - J-type: sext({ir[31],ir[19:12],ir[20],ir[30:21],0}).
  - All other opcodes: 0.
- Illegal: ir[1:0]!=2'b11, or opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}. x_illegal_o is only meaningful when x_valid_o=1.

Test Plan:
- Reset: hold rst_n_i=0 while driving a valid word → every x_* output is 0. After release, f_ir_i=0xFFB10093 (ADDI x1,x2,-5), f_pc_i=0x100 → next cycle x_valid_o=1, x_rd_o=1, x_rs1_o=2, x_imm_o=0xFFFFFFFB, x_pc_o=0x100.
- Load-use: 0x00032283 (LW x5,0(x6)) followed by 0x001283B3 (ADD x7,x5,x1) → f_stall_o=1 for exactly one cycle and x_valid_o=0 for one cycle. The ADD then issues with x_rs1_o=5, x_rs2_o=1. Repeat the pair with rd=x0 → no bubble.
- JAL x0,-4 (0xFFDFF06F) → x_is_jump_o=1, x_imm_o=0xFFFFFFFC, x_rd_o=0, and f_stall_o stays 0 with a preceding load of x5.
- Kill: assert d_kill_i during a cycle where a load-use hazard would fire → no fetch stall; next cycle x_valid_o=0.
- Stall: d_stall_i=1 for 3 cycles while f_ir_i changes → x_* outputs and d_rf_rs1_o hold their values; f_stall_o=1 throughout.
- Illegal: f_ir_i=0x00000000 → x_illegal_o=1. With f_ir_i=0x00000073 (ECALL) → x_illegal_o=0.
